// File: rtl/timer_bank.sv
// timer_bank: CHANNELS down-counters sharing one prescaler and load port, one-shot or periodic.
// Define TIMER_IRQ_EN to build the registered, masked irq merge; otherwise irq is tied low.
module timer_bank #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic                      load,
    input  logic [CH_W-1:0]           load_ch,
    input  logic                      load_mode,
    input  logic [WIDTH-1:0]          timer_load,
    input  logic [CHANNELS-1:0]       timeout_clr,
    input  logic [CHANNELS-1:0]       irq_mask,
    output logic [CHANNELS-1:0]       timeout,
    output logic [CHANNELS*WIDTH-1:0] timervalue,
    output logic                      irq
);
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;

    // >= rather than == so lowering prescale mid-count wraps at once
    assign tick = pre_cnt >= prescale;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_cnt <= '0;
        else      pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt, reload;
        logic             mode, to, hit, dec;
        assign hit = load && (load_ch == CH_W'(i));
        assign dec = tick && enable[i] && (cnt != '0);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt    <= '0;
                reload <= '0;
                mode   <= 1'b0;
                to     <= 1'b0;
            end else if (hit) begin
                cnt    <= timer_load;
                reload <= timer_load;
                mode   <= load_mode;
                to     <= 1'b0;
            end else begin
                // periodic channels jump from 1 straight to reload, never showing 0
                if (dec) cnt <= (cnt == WIDTH'(1) && mode) ? reload : cnt - WIDTH'(1);
                if (dec && cnt == WIDTH'(1)) to <= 1'b1;
                else if (timeout_clr[i])     to <= 1'b0;
            end
        end
        assign timervalue[i*WIDTH +: WIDTH] = cnt;
        assign timeout[i] = to;
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= |(timeout & irq_mask);
    end
`else
    logic unused_mask;
    assign unused_mask = ^irq_mask;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios for timer_bank (WIDTH=32, CHANNELS=4, PRESCALE_W=8).
module tb_timer_bank;
`ifdef TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   enable, timeout_clr, irq_mask, timeout;
    logic [7:0]   prescale;
    logic         load, load_mode, irq;
    logic [1:0]   load_ch;
    logic [31:0]  timer_load;
    logic [127:0] timervalue;
    int           errors = 0;
    int           checks = 0;

    timer_bank #(.WIDTH(32), .CHANNELS(4), .PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .load(load),
        .load_ch(load_ch), .load_mode(load_mode), .timer_load(timer_load),
        .timeout_clr(timeout_clr), .irq_mask(irq_mask), .timeout(timeout),
        .timervalue(timervalue), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tv(input int ch);
        return timervalue[ch*32 +: 32];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [31:0] val, input logic mode);
        load = 1'b1; load_ch = ch; timer_load = val; load_mode = mode;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; enable = '0; prescale = '0; load = 1'b0; load_ch = '0;
        load_mode = 1'b0; timer_load = '0; timeout_clr = '0; irq_mask = '0;
        #2;
        checks++; if (timervalue !== '0) begin errors++; $display("FAIL reset_tv got=%h exp=0", timervalue); end
        checks++; if (timeout !== 4'b0) begin errors++; $display("FAIL reset_to got=%b exp=0000", timeout); end
        step(2);
        rst = 1'b1;
        enable = 4'b0001;
        do_load(2'd0, 32'd7, 1'b0);
        step(2);
        checks++; if (tv(0) !== 32'd5) begin errors++; $display("FAIL pre_rst_ch0 got=%0d exp=5", tv(0)); end
        #2 rst = 1'b0;
        #1;
        checks++; if (tv(0) !== 32'd0) begin errors++; $display("FAIL async_rst_tv got=%0d exp=0", tv(0)); end
        checks++; if (timeout !== 4'b0) begin errors++; $display("FAIL async_rst_to got=%b exp=0000", timeout); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_rst_irq got=%b exp=0", irq); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_oneshot;
        prescale = 8'd0; enable = 4'b0001;
        do_load(2'd0, 32'd5, 1'b0);
        checks++; if (tv(0) !== 32'd5) begin errors++; $display("FAIL os_load got=%0d exp=5", tv(0)); end
        for (int k = 4; k >= 0; k--) begin
            step();
            checks++; if (tv(0) !== 32'(k)) begin errors++; $display("FAIL os_cnt got=%0d exp=%0d", tv(0), k); end
            checks++; if (timeout[0] !== (k == 0)) begin errors++; $display("FAIL os_to k=%0d got=%b exp=%b", k, timeout[0], k == 0); end
        end
        step(2);
        checks++; if (tv(0) !== 32'd0 || timeout[0] !== 1'b1) begin errors++; $display("FAIL os_hold got=%0d/%b exp=0/1", tv(0), timeout[0]); end
    endtask

    task automatic test_periodic;
        logic [31:0] exp_v [9];
        logic        exp_t [9];
        exp_v = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd3, 32'd3, 32'd2};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        enable = 4'b0010; prescale = 8'd1;
        step();
        do_load(2'd1, 32'd3, 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            checks++; if (tv(1) !== exp_v[k]) begin errors++; $display("FAIL per_cnt k=%0d got=%0d exp=%0d", k, tv(1), exp_v[k]); end
            checks++; if (timeout[1] !== exp_t[k]) begin errors++; $display("FAIL per_to k=%0d got=%b exp=%b", k, timeout[1], exp_t[k]); end
        end
    endtask

    task automatic test_load_priority;
        enable = 4'b0100; prescale = 8'd0;
        do_load(2'd2, 32'd2, 1'b1);
        step(2);
        checks++; if (tv(2) !== 32'd2 || timeout[2] !== 1'b1) begin errors++; $display("FAIL lp_pre got=%0d/%b exp=2/1", tv(2), timeout[2]); end
        do_load(2'd2, 32'd9, 1'b1);
        checks++; if (tv(2) !== 32'd9) begin errors++; $display("FAIL lp_cnt got=%0d exp=9", tv(2)); end
        checks++; if (timeout[2] !== 1'b0) begin errors++; $display("FAIL lp_to got=%b exp=0", timeout[2]); end
        step();
        checks++; if (tv(2) !== 32'd8) begin errors++; $display("FAIL lp_next got=%0d exp=8", tv(2)); end
        checks++; if (tv(1) !== 32'd2) begin errors++; $display("FAIL lp_other got=%0d exp=2", tv(1)); end
    endtask

    task automatic test_clr_collision;
        enable = 4'b0001; prescale = 8'd0;
        do_load(2'd0, 32'd2, 1'b0);
        checks++; if (timeout[0] !== 1'b0) begin errors++; $display("FAIL cc_load got=%b exp=0", timeout[0]); end
        step();
        timeout_clr = 4'b0001;
        step();
        checks++; if (tv(0) !== 32'd0 || timeout[0] !== 1'b1) begin errors++; $display("FAIL cc_setwins got=%0d/%b exp=0/1", tv(0), timeout[0]); end
        timeout_clr = 4'b0000;
        step();
        checks++; if (timeout[0] !== 1'b1) begin errors++; $display("FAIL cc_sticky got=%b exp=1", timeout[0]); end
        timeout_clr = 4'b0001;
        step();
        timeout_clr = 4'b0000;
        checks++; if (timeout[0] !== 1'b0) begin errors++; $display("FAIL cc_clr got=%b exp=0", timeout[0]); end
    endtask

    task automatic test_enable_irq;
        enable = 4'b1000; prescale = 8'd0;
        do_load(2'd3, 32'd6, 1'b1);
        step();
        enable = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (tv(3) !== 32'd5) begin errors++; $display("FAIL en_hold k=%0d got=%0d exp=5", k, tv(3)); end
        end
        enable = 4'b1000;
        step();
        checks++; if (tv(3) !== 32'd4) begin errors++; $display("FAIL en_resume got=%0d exp=4", tv(3)); end
        enable = 4'b0000; irq_mask = 4'b0010; timeout_clr = 4'b1111;
        step();
        timeout_clr = 4'b0000;
        step();
        checks++; if (timeout !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b/%b exp=0000/0", timeout, irq); end
        enable = 4'b0001;
        do_load(2'd0, 32'd1, 1'b0);
        step(2);
        checks++; if (timeout[0] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b/%b exp=1/0", timeout[0], irq); end
        enable = 4'b0010;
        do_load(2'd1, 32'd1, 1'b1);
        step();
        checks++; if (timeout[1] !== 1'b1 || irq !== 1'b0 || tv(1) !== 32'd1) begin errors++; $display("FAIL irq_lag got=%b/%b/%0d exp=1/0/1", timeout[1], irq, tv(1)); end
        step();
        checks++; if (irq !== IRQ_EN) begin errors++; $display("FAIL irq_set got=%b exp=%b", irq, IRQ_EN); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_load_priority();
        test_clr_collision();
        test_enable_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
